// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;

    // Default UART bit period in system clocks; the inter-byte timeout is 20 bit times.
    localparam int CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CSUM    = 3'd1,
        ERR_TIMEOUT = 3'd2,
        ERR_BAD_CMD = 3'd3,
        ERR_BAD_LEN = 3'd4,
        ERR_OVERRUN = 3'd5
    } err_code_t;

    // 8-bit wrapping checksum accumulation.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload staging buffer: register file written while a frame is received,
// read combinationally by the commit sequencer. Storage is not reset.
module uart_cmd_buf #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_idx,
    output logic [7:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    logic [7:0] mem [DEPTH];

    // Store each payload byte at its index; out-of-range indices are ignored.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_idx} < DEPTH_W)) begin
            mem[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    // Out-of-range reads (one past the last beat) return zero.
    assign rd_data = ({1'b0, rd_idx} < DEPTH_W) ? mem[rd_idx[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command frame parser and sequencer: hunts the sync byte, collects
// CMD/ADDR/LEN/payload/CSUM, verifies the checksum, then streams register
// writes or issues a single read request.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_Valid,
    input  logic       i_Wr_Ready,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Rd_Req,
    output logic [7:0] o_Rd_Addr,
    output logic [7:0] o_Rd_Len,
    output logic       o_Busy,
    output logic       o_Err,
    output logic [2:0] o_Err_Code,
    output logic [7:0] o_Frame_Cnt
);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t          state_reg, state_next;
    err_code_t       err_code_reg, err_code_next;
    logic            is_write_reg, is_write_next;
    logic [7:0]      addr_reg, addr_next;
    logic [7:0]      len_reg, len_next;
    logic [7:0]      csum_reg, csum_next;
    logic [7:0]      pay_idx_reg, pay_idx_next;
    logic [7:0]      commit_cnt_reg, commit_cnt_next;
    logic [TW-1:0]   tcnt_reg, tcnt_next;
    logic            wr_valid_reg, wr_valid_next;
    logic [7:0]      wr_addr_reg, wr_addr_next;
    logic [7:0]      wr_data_reg, wr_data_next;
    logic            rd_req_reg, rd_req_next;
    logic [7:0]      rd_addr_reg, rd_addr_next;
    logic [7:0]      rd_len_reg, rd_len_next;
    logic            err_reg, err_next;
    logic [7:0]      frame_cnt_reg, frame_cnt_next;

    logic            buf_wr_en;
    logic [7:0]      buf_rd_idx;
    logic [7:0]      buf_rd_data;
    logic [7:0]      csum_with_byte;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (buf_wr_en),
        .wr_idx  (pay_idx_reg),
        .wr_data (i_RX_Byte),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    assign csum_with_byte = csum_add(csum_reg, i_RX_Byte);

    // Next-state, datapath and output logic; a received byte always takes priority over timeout.
    always_comb begin
        state_next      = state_reg;
        err_code_next   = err_code_reg;
        is_write_next   = is_write_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        csum_next       = csum_reg;
        pay_idx_next    = pay_idx_reg;
        commit_cnt_next = commit_cnt_reg;
        tcnt_next       = tcnt_reg;
        wr_valid_next   = wr_valid_reg;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        rd_req_next     = 1'b0;
        rd_addr_next    = rd_addr_reg;
        rd_len_next     = rd_len_reg;
        err_next        = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        buf_wr_en       = 1'b0;
        buf_rd_idx      = 8'd0;

        case (state_reg)
            ST_IDLE: begin
                tcnt_next = '0;
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    csum_next    = 8'd0;
                    pay_idx_next = 8'd0;
                    state_next   = ST_CMD;
                end
            end

            ST_COMMIT: begin
                // Prefetch the byte for the beat after the current one.
                buf_rd_idx = commit_cnt_reg + 8'd1;
                if (i_RX_DV) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_OVERRUN;
                end
                if (wr_valid_reg && i_Wr_Ready) begin
                    if (commit_cnt_reg == (len_reg - 8'd1)) begin
                        wr_valid_next   = 1'b0;
                        commit_cnt_next = 8'd0;
                        frame_cnt_next  = frame_cnt_reg + 8'd1;
                        state_next      = ST_IDLE;
                    end else begin
                        commit_cnt_next = commit_cnt_reg + 8'd1;
                        wr_addr_next    = wr_addr_reg + 8'd1;
                        wr_data_next    = buf_rd_data;
                    end
                end
            end

            default: begin
                if (i_RX_DV) begin
                    tcnt_next = '0;
                    case (state_reg)
                        ST_CMD: begin
                            if ((i_RX_Byte == CMD_WR) || (i_RX_Byte == CMD_RD)) begin
                                is_write_next = (i_RX_Byte == CMD_WR);
                                csum_next     = csum_with_byte;
                                state_next    = ST_ADDR;
                            end else begin
                                err_next      = 1'b1;
                                err_code_next = ERR_BAD_CMD;
                                state_next    = ST_IDLE;
                            end
                        end
                        ST_ADDR: begin
                            addr_next  = i_RX_Byte;
                            csum_next  = csum_with_byte;
                            state_next = ST_LEN;
                        end
                        ST_LEN: begin
                            if ((i_RX_Byte == 8'd0) || (is_write_reg && (i_RX_Byte > MAX_LEN_B))) begin
                                err_next      = 1'b1;
                                err_code_next = ERR_BAD_LEN;
                                state_next    = ST_IDLE;
                            end else begin
                                len_next   = i_RX_Byte;
                                csum_next  = csum_with_byte;
                                state_next = is_write_reg ? ST_PAYLOAD : ST_CSUM;
                            end
                        end
                        ST_PAYLOAD: begin
                            buf_wr_en    = 1'b1;
                            csum_next    = csum_with_byte;
                            pay_idx_next = pay_idx_reg + 8'd1;
                            if (pay_idx_reg == (len_reg - 8'd1)) begin
                                state_next = ST_CSUM;
                            end
                        end
                        ST_CSUM: begin
                            if (csum_with_byte != 8'd0) begin
                                err_next      = 1'b1;
                                err_code_next = ERR_CSUM;
                                state_next    = ST_IDLE;
                            end else if (is_write_reg) begin
                                wr_valid_next   = 1'b1;
                                wr_addr_next    = addr_reg;
                                wr_data_next    = buf_rd_data;
                                commit_cnt_next = 8'd0;
                                state_next      = ST_COMMIT;
                            end else begin
                                rd_req_next    = 1'b1;
                                rd_addr_next   = addr_reg;
                                rd_len_next    = len_reg;
                                frame_cnt_next = frame_cnt_reg + 8'd1;
                                state_next     = ST_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end else if (tcnt_reg == T_LAST) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_TIMEOUT;
                    state_next    = ST_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame or commit in progress.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg      <= ST_IDLE;
            err_code_reg   <= ERR_NONE;
            is_write_reg   <= 1'b0;
            addr_reg       <= 8'd0;
            len_reg        <= 8'd0;
            csum_reg       <= 8'd0;
            pay_idx_reg    <= 8'd0;
            commit_cnt_reg <= 8'd0;
            tcnt_reg       <= '0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= 8'd0;
            wr_data_reg    <= 8'd0;
            rd_req_reg     <= 1'b0;
            rd_addr_reg    <= 8'd0;
            rd_len_reg     <= 8'd0;
            err_reg        <= 1'b0;
            frame_cnt_reg  <= 8'd0;
        end else begin
            state_reg      <= state_next;
            err_code_reg   <= err_code_next;
            is_write_reg   <= is_write_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            csum_reg       <= csum_next;
            pay_idx_reg    <= pay_idx_next;
            commit_cnt_reg <= commit_cnt_next;
            tcnt_reg       <= tcnt_next;
            wr_valid_reg   <= wr_valid_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            rd_req_reg     <= rd_req_next;
            rd_addr_reg    <= rd_addr_next;
            rd_len_reg     <= rd_len_next;
            err_reg        <= err_next;
            frame_cnt_reg  <= frame_cnt_next;
        end
    end

    assign o_Wr_Valid  = wr_valid_reg;
    assign o_Wr_Addr   = wr_addr_reg;
    assign o_Wr_Data   = wr_data_reg;
    assign o_Rd_Req    = rd_req_reg;
    assign o_Rd_Addr   = rd_addr_reg;
    assign o_Rd_Len    = rd_len_reg;
    assign o_Busy      = (state_reg != ST_IDLE);
    assign o_Err       = err_reg;
    assign o_Err_Code  = err_code_reg;
    assign o_Frame_Cnt = frame_cnt_reg;

endmodule
